// File: rtl/fir_result_fifo.sv
// fir_result_fifo: result buffer behind the last stage of the cascaded FIR chain.
// Registers the chain's enable strobe and samples acc_in one cycle later. It
// keeps 1 of every DECIM results and queues the kept results in a DEPTH-entry
// show-ahead FIFO that is read over a valid/ready handshake.
//   clk, reset       : system clock and synchronous active-high reset
//   enable, acc_in   : FIR sample strobe and the final-stage accumulator output
//   flush, clear_ovf : empty the FIFO / clear the sticky overflow flag
//   data_out, valid_out, ready_in : reader handshake (show-ahead head entry)
//   count, overflow  : fill level and sticky dropped-result flag
module fir_result_fifo #(
  parameter int DEPTH = 8,
  parameter int DECIM = 1,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [15:0]      acc_in,
  input  logic             flush,
  input  logic             clear_ovf,
  output logic [15:0]      data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [15:0]      mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_next;
  logic [PW-1:0]    phase;
  logic             enable_d;
  logic             keep;
  logic             full;
  logic             pop;
  logic             push;
  logic [CNT_W-1:0] count_next;

  assign valid_out = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign pop       = valid_out & ready_in;
  assign keep      = enable_d & (phase == '0);
  assign push      = keep & (~full | pop);
  assign rd_next   = pop ? rd_ptr + AW'(1) : rd_ptr;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && push) begin
      mem[wr_ptr] <= acc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      phase    <= '0;
      enable_d <= 1'b0;
      overflow <= 1'b0;
      data_out <= '0;
    end else begin
      enable_d <= enable;
      if (clear_ovf) begin
        overflow <= 1'b0;
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        phase  <= '0;
      end else begin
        if (enable_d) begin
          phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
        end
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        // set wins over clear_ovf on the same edge
        if (keep && full && !pop) begin
          overflow <= 1'b1;
        end
        rd_ptr <= rd_next;
        count  <= count_next;
        // registered show-ahead head; the entry written this edge becomes the
        // head when the read pointer lands on the write slot
        if (count_next != '0) begin
          data_out <= (push && (wr_ptr == rd_next)) ? acc_in : mem[rd_next];
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_result_fifo.sv
module tb_fir_result_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] acc_in = '0;
  logic        flush = 1'b0;
  logic        clear_ovf = 1'b0;
  logic        ready_in = 1'b0;

  logic [15:0] data1, data4;
  logic        valid1, valid4;
  logic [3:0]  count1, count4;
  logic        ovf1, ovf4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fir_result_fifo #(.DEPTH(8), .DECIM(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .acc_in(acc_in),
    .flush(flush), .clear_ovf(clear_ovf), .data_out(data1),
    .valid_out(valid1), .ready_in(ready_in), .count(count1), .overflow(ovf1)
  );

  fir_result_fifo #(.DEPTH(8), .DECIM(4), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .acc_in(acc_in),
    .flush(flush), .clear_ovf(clear_ovf), .data_out(data4),
    .valid_out(valid4), .ready_in(ready_in), .count(count4), .overflow(ovf4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // enable pulse, then the FIR result appears on acc_in the following cycle
  task automatic strobe(input logic [15:0] v);
    enable = 1'b1;
    acc_in = 16'hDEAD;
    tick();
    enable = 1'b0;
    acc_in = v;
    tick();
  endtask

  task automatic pop_one();
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid1); end
    checks++; if (count1 !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count1); end
    checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf1); end
    checks++; if (data1 !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", data1); end
    checks++; if (count4 !== 4'd0) begin errors++; $display("FAIL reset_count4: got %0d expected 0", count4); end
  endtask

  task automatic test_capture_latency();
    do_reset();
    enable = 1'b1;
    acc_in = 16'hBEEF;
    tick();
    enable = 1'b0;
    acc_in = 16'h1234;
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL lat_early_valid: got %b expected 0", valid1); end
    tick();
    checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL lat_valid: got %b expected 1", valid1); end
    checks++; if (data1 !== 16'h1234) begin errors++; $display("FAIL lat_data: got %h expected 1234", data1); end
    checks++; if (count1 !== 4'd1) begin errors++; $display("FAIL lat_count: got %0d expected 1", count1); end
    acc_in = 16'h5555;
    tick();
    tick();
    checks++; if (count1 !== 4'd1) begin errors++; $display("FAIL lat_nocap_count: got %0d expected 1", count1); end
    checks++; if (data1 !== 16'h1234) begin errors++; $display("FAIL lat_hold_data: got %h expected 1234", data1); end
  endtask

  task automatic test_decimation();
    do_reset();
    for (int v = 1; v <= 8; v++) strobe(16'(v));
    checks++; if (count4 !== 4'd2) begin errors++; $display("FAIL dec_count: got %0d expected 2", count4); end
    checks++; if (data4 !== 16'd1) begin errors++; $display("FAIL dec_head0: got %h expected 0001", data4); end
    pop_one();
    checks++; if (data4 !== 16'd5) begin errors++; $display("FAIL dec_head1: got %h expected 0005", data4); end
    pop_one();
    checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL dec_empty: got %b expected 0", valid4); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int v = 16'h10; v <= 16'h17; v++) strobe(16'(v));
    checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL ovf_at_full: got %b expected 0", ovf1); end
    strobe(16'h18);
    strobe(16'h19);
    checks++; if (count1 !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", count1); end
    checks++; if (ovf1 !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", ovf1); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (valid1 !== 1'b1 || data1 !== 16'(16'h10 + i)) begin
        errors++; $display("FAIL ovf_drain%0d: got v=%b %h expected v=1 %h", i, valid1, data1, 16'(16'h10 + i));
      end
      pop_one();
    end
    checks++; if (count1 !== 4'd0) begin errors++; $display("FAIL ovf_drained: got %0d expected 0", count1); end
    // empty with ready held: no underflow
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    checks++; if (count1 !== 4'd0) begin errors++; $display("FAIL ovf_underflow: got %0d expected 0", count1); end
    checks++; if (ovf1 !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf1); end
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ovf1); end
    for (int v = 16'h20; v <= 16'h27; v++) strobe(16'(v));
    enable = 1'b1;
    tick();
    enable = 1'b0;
    acc_in = 16'h28;
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    checks++; if (ovf1 !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", ovf1); end
    checks++; if (count1 !== 4'd8 || data1 !== 16'h20) begin errors++; $display("FAIL ovf_store_kept: got %0d %h expected 8 0020", count1, data1); end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int v = 16'h30; v <= 16'h37; v++) strobe(16'(v));
    enable = 1'b1;
    tick();
    enable = 1'b0;
    acc_in = 16'h38;
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    checks++; if (count1 !== 4'd8) begin errors++; $display("FAIL fullpop_count: got %0d expected 8", count1); end
    checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL fullpop_ovf: got %b expected 0", ovf1); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (data1 !== 16'(16'h31 + i)) begin
        errors++; $display("FAIL fullpop_drain%0d: got %h expected %h", i, data1, 16'(16'h31 + i));
      end
      pop_one();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ready_in = 1'b1;
    enable = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      acc_in = 16'(i);
      tick();
      checks++;
      if (valid1 !== 1'b1 || data1 !== 16'(i) || count1 !== 4'd1) begin
        errors++; $display("FAIL b2b_%0d: got v=%b %h c=%0d expected v=1 %h c=1", i, valid1, data1, count1, 16'(i));
      end
    end
    enable = 1'b0;
    tick();
    tick();
    ready_in = 1'b0;
    checks++; if (count1 !== 4'd0) begin errors++; $display("FAIL b2b_drain: got %0d expected 0", count1); end
  endtask

  task automatic test_flush_reset();
    do_reset();
    for (int v = 16'h50; v <= 16'h58; v++) strobe(16'(v));
    for (int i = 0; i < 3; i++) pop_one();
    checks++; if (count1 !== 4'd5 || ovf1 !== 1'b1) begin errors++; $display("FAIL fl_setup: got %0d %b expected 5 1", count1, ovf1); end
    enable = 1'b1;
    tick();
    enable = 1'b0;
    acc_in = 16'h77;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (count1 !== 4'd0 || valid1 !== 1'b0) begin errors++; $display("FAIL fl_empty: got %0d %b expected 0 0", count1, valid1); end
    checks++; if (ovf1 !== 1'b1) begin errors++; $display("FAIL fl_ovf_kept: got %b expected 1", ovf1); end
    checks++; if (count4 !== 4'd0) begin errors++; $display("FAIL fl_empty4: got %0d expected 0", count4); end
    strobe(16'h41);
    checks++; if (count1 !== 4'd1 || data1 !== 16'h41) begin errors++; $display("FAIL fl_next: got %0d %h expected 1 0041", count1, data1); end
    checks++; if (count4 !== 4'd1 || data4 !== 16'h41) begin errors++; $display("FAIL fl_phase4: got %0d %h expected 1 0041", count4, data4); end
    for (int v = 16'h60; v <= 16'h63; v++) strobe(16'(v));
    checks++; if (count1 !== 4'd5) begin errors++; $display("FAIL rs_setup: got %0d expected 5", count1); end
    enable = 1'b1;
    tick();
    enable = 1'b0;
    acc_in = 16'h99;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (count1 !== 4'd0 || valid1 !== 1'b0) begin errors++; $display("FAIL rs_empty: got %0d %b expected 0 0", count1, valid1); end
    checks++; if (ovf1 !== 1'b0 || data1 !== 16'h0) begin errors++; $display("FAIL rs_ovf_data: got %b %h expected 0 0000", ovf1, data1); end
    strobe(16'h42);
    checks++; if (count1 !== 4'd1 || data1 !== 16'h42) begin errors++; $display("FAIL rs_next: got %0d %h expected 1 0042", count1, data1); end
    checks++; if (count4 !== 4'd1 || data4 !== 16'h42) begin errors++; $display("FAIL rs_phase4: got %0d %h expected 1 0042", count4, data4); end
  endtask

  initial begin
    #1;
    test_reset();
    test_capture_latency();
    test_decimation();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_flush_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
